// File: rtl/tristate_bus_pkg.sv
// Shared types and defaults for the tri-state bus read master.
// Holds the FSM state encoding and the default bus width and WAIT timeout.
package tristate_bus_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_TURN,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/bus_tri_drv.sv
// Per-bit tri-state driver: bus follows data while oe=1, otherwise floats (z).
// Purely combinational, zero latency, and never applies backpressure.
module bus_tri_drv #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             oe,
  inout  wire  [WIDTH-1:0] bus
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bufif1 u_buf (bus[i], data[i], oe);
  end

endmodule

// File: rtl/tristate_bus_reader.sv
// Read master on a shared tri-state bus: ADDR drive, TURN, then WAIT for ack or timeout.
// Done arrives one cycle after ack (minimum 4 cycles); start is ignored unless IDLE.
module tristate_bus_reader
  import tristate_bus_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] addr,
  inout  wire  [WIDTH-1:0] bus,
  output logic             bus_oe,
  output logic             sel,
  input  logic             ack,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic             done,
  output logic             timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] addr_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             cnt_last;

  assign cnt_last = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      wait_cnt <= '0;
      rd_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        addr_q <= addr;
      end
      // Cleared while in TURN so the first WAIT cycle sees zero.
      if (state == ST_TURN) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (state == ST_WAIT && ack) begin
        rd_data <= bus;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ADDR;
      ST_ADDR: state_nxt = ST_TURN;
      ST_TURN: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (ack) begin
          state_nxt = ST_DONE;
        end else if (cnt_last) begin
          state_nxt = ST_ERR;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_oe      = 1'b0;
    sel         = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    timeout_err = 1'b0;
    case (state)
      ST_IDLE: busy = 1'b0;
      ST_ADDR: begin
        bus_oe = 1'b1;
        sel    = 1'b1;
      end
      ST_TURN: sel = 1'b1;
      ST_WAIT: sel = 1'b1;
      ST_DONE: done = 1'b1;
      ST_ERR:  timeout_err = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  bus_tri_drv #(
    .WIDTH (WIDTH)
  ) u_drv (
    .data (addr_q),
    .oe   (bus_oe),
    .bus  (bus)
  );

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Bench for tristate_bus_reader: responder model plus completion scoreboard.
module tb_tristate_bus_reader;

  localparam int W  = 8;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] addr;
  wire  [W-1:0] bus;
  logic         bus_oe;
  logic         sel;
  logic         ack;
  logic         busy;
  logic [W-1:0] rd_data;
  logic         done;
  logic         timeout_err;
  logic         resp_oe;
  logic [W-1:0] resp_dat;

  always #5 clk = ~clk;

  assign bus = resp_oe ? resp_dat : {W{1'bz}};

  tristate_bus_reader #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .addr        (addr),
    .bus         (bus),
    .bus_oe      (bus_oe),
    .sel         (sel),
    .ack         (ack),
    .busy        (busy),
    .rd_data     (rd_data),
    .done        (done),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic         err;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  logic [W-1:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Every done/timeout_err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done || timeout_err) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", {30'd0, done, timeout_err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("outcome", {30'd0, done, timeout_err}, mon_e.err ? 32'd1 : 32'd2);
        check("rd_data", {24'd0, rd_data}, {24'd0, mon_e.data});
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // ack_k: cycle (relative to the start edge) in which the responder acks; 0 = never.
  task automatic read_txn(input logic [W-1:0] a, input int ack_k, input logic [W-1:0] d);
    int   t0;
    int   end_k;
    exp_t e;
    @(negedge clk);
    addr  = a;
    start = 1'b1;
    t0    = cyc;
    if (ack_k >= 3 && ack_k <= 2 + TO) begin
      e.err     = 1'b0;
      e.data    = d;
      end_k     = ack_k + 1;
      last_data = d;
    end else begin
      e.err  = 1'b1;
      e.data = last_data;
      end_k  = 3 + TO;
    end
    e.cyc = t0 + end_k;
    sb.push_back(e);
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      start   = 1'b0;
      addr    = 8'hEE;
      ack     = 1'b0;
      resp_oe = 1'b0;
      if (k == 1) begin
        check("addr_oe", {31'd0, bus_oe}, 32'd1);
        check("addr_bus", {24'd0, bus}, {24'd0, a});
        check("addr_sel", {31'd0, sel}, 32'd1);
      end else if (k < end_k) begin
        check("wait_oe", {31'd0, bus_oe}, 32'd0);
        check("wait_sel", {31'd0, sel}, 32'd1);
      end
      if (k == ack_k) begin
        ack      = 1'b1;
        resp_oe  = 1'b1;
        resp_dat = d;
      end
    end
    @(negedge clk);
    check("idle_after", {31'd0, busy}, 32'd0);
  endtask

  // start held high: one transaction every 5 cycles, addr captured only at acceptance.
  task automatic back_to_back();
    int   t0;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    addr  = 8'h11;
    t0    = cyc;
    for (int i = 0; i < 3; i++) begin
      e.err  = 1'b0;
      e.data = 8'h21 + 8'(i);
      e.cyc  = t0 + 4 + 5 * i;
      sb.push_back(e);
    end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      ack     = 1'b0;
      resp_oe = 1'b0;
      case (k % 5)
        1: begin
          check("b2b_oe", {31'd0, bus_oe}, 32'd1);
          check("b2b_bus", {24'd0, bus}, 32'h11 + 32'(k / 5));
          addr = 8'hEE;
        end
        3: begin
          ack      = 1'b1;
          resp_oe  = 1'b1;
          resp_dat = 8'h21 + 8'(k / 5);
        end
        0: begin
          check("b2b_idle", {31'd0, busy}, 32'd0);
          addr = 8'h11 + 8'(k / 5);
          if (k == 15) start = 1'b0;
        end
        default: ;
      endcase
    end
    @(negedge clk);
    check("b2b_stop", {31'd0, busy}, 32'd0);
    last_data = 8'h23;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    ack      = 1'b0;
    addr     = '0;
    resp_oe  = 1'b0;
    resp_dat = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sel", {31'd0, sel}, 32'd0);
    check("rst_oe", {31'd0, bus_oe}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_terr", {31'd0, timeout_err}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    rst = 1'b0;

    read_txn(8'h3C, 3, 8'hA5);   // minimum latency
    read_txn(8'h81, 7, 8'h5A);   // ack in 5th WAIT cycle
    read_txn(8'h42, 0, 8'h00);   // timeout, rd_data keeps 5A
    read_txn(8'h24, 17, 8'hC3);  // ack on final WAIT cycle
    read_txn(8'h99, 2, 8'h77);   // ack only during TURN is ignored
    back_to_back();

    // Reset while in WAIT: no pulse, everything back to reset values.
    @(negedge clk);
    start = 1'b1;
    addr  = 8'h42;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_wait", {31'd0, sel}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_sel", {31'd0, sel}, 32'd0);
    check("mid_rst_oe", {31'd0, bus_oe}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_terr", {31'd0, timeout_err}, 32'd0);
    check("mid_rst_rd_data", {24'd0, rd_data}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
